io_port_ctrl: RTL and testbench
===============================

# io_port_ctrl

Memory-mapped I/O controller on the LEGLiteSingle data bus, alongside data memory. Decodes the CPU data address/strobes, debounces and synchronizes slide switches sw0/sw1, latches a 4-bit display value and drives the 7-segment output. Keeps sticky switch-change flags so firmware can poll for edges instead of sampling levels. Reads are combinational for the single-cycle CPU; all state updates on the rising clock edge.

## Interface

Parameters:
- ADDR_SW, 16'hFFF0, switch level register (read-only)
- ADDR_STAT, 16'hFFF2, switch-change flag register (read, clear-on-read)
- ADDR_DISP, 16'hFFF4, display register (read/write)
- DB_CYCLES, 4, consecutive cycles a synchronized switch must differ from its stable value before the stable value updates (legal range 1..65535)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- draddr  input  16  CPU data address
- dwdata  input  16  CPU write data
- dwrite  input  1  write enable
- dread  input  1  read enable
- io_sw0  input  1  raw switch 0 (asynchronous)
- io_sw1  input  1  raw switch 1 (asynchronous)
- io_rdata  output  16  read data; 0 when not hit
- io_hit  output  1  draddr matches one of the three addresses (read mux select for the data path)
- io_display  output  7  segments {g,f,e,d,c,b,a}, active-high

## Operation

- Per switch i: two-flop synchronizer s1_i→s2_i, 16-bit counter cnt_i, stable bit st_i, sticky flag chg_i.
- Debounce per edge: if s2_i == st_i then cnt_i <= 0; else if cnt_i == DB_CYCLES-1 then st_i <= s2_i, cnt_i <= 0, chg_i <= 1; else cnt_i <= cnt_i+1.
- Reads (combinational, gated by dread): ADDR_SW → {14'b0, st1, st0}; ADDR_STAT → {14'b0, chg1, chg0}; ADDR_DISP → {11'b0, blank, dval[3:0]}; other addresses or dread=0 → 0.
- io_hit = address match only, independent of dread/dwrite.
- Clear-on-read: at an edge with dread=1 and draddr==ADDR_STAT, chg_i <= 0, except a chg_i set in the same edge wins (set priority).
- Writes at the edge with dwrite=1, draddr==ADDR_DISP: dval <= dwdata[3:0], blank <= dwdata[4]; bits 15:5 ignored. Writes to ADDR_SW/ADDR_STAT are ignored.
- Simultaneous dread and dwrite to ADDR_DISP: read returns the old value; new value stored at the edge.
- Display: blank=1 → 7'b0000000; else hex decode of dval, e.g. 0→0111111, 1→0000110, 2→1011011, 8→1111111, A→1110111, F→1110001.

## Timing

- Reset (reset=0, asynchronous): s1,s2,st,cnt,chg,dval,blank all 0; io_display = 7'b0111111 immediately; io_rdata=0 when dread=0.
- Switch latency: raw change just before edge 1 → s2 at edge 2 → st and chg update at edge 2+DB_CYCLES (edge 6 at default).
- Glitch shorter than DB_CYCLES cycles at s2: counter returns to 0, st and chg unchanged.
- Counter never exceeds DB_CYCLES-1; no wrap.
- Display write visible on io_display and ADDR_DISP read in the cycle after the write edge.
- Reset asserted mid-debounce discards the count; after release, a still-changed switch needs the full 2+DB_CYCLES edges again.

## Test plan

- Reset: reset=0 → io_display=0111111, reads of all three addresses return 0x0000.
- Debounce: io_sw0 0→1 held → ADDR_SW reads 0x0001 and ADDR_STAT 0x0001 exactly after the 6th edge (DB_CYCLES=4), not after the 5th.
- Glitch: io_sw1 high for 3 cycles then low → ADDR_SW and ADDR_STAT stay 0x0000.
- Clear-on-read: read ADDR_STAT=0x0001, next read 0x0000; flag set on the same edge as the read → next read still 0x0001.
- Display: write 0x0008 → io_display=1111111, readback 0x0008; write 0x0013 → io_display=0000000, readback 0x0013; write to ADDR_SW → no state change.
- Address decode: dread=1 at 0x0004 → io_hit=0, io_rdata=0; at 0xFFF4 → io_hit=1.

Source files
------------

// File: rtl/io_port_ctrl.sv
// Memory-mapped switch/display I/O port on the CPU data bus: debounced switches, sticky change flags, 7-segment display.
// Latency: reads are combinational; switch level reaches st/chg at edge 2+DB_CYCLES; a display write is visible the cycle after it lands.
// Backpressure: none. Every bus access completes in one cycle, and io_hit selects this block's read data in the CPU data path.
module io_port_ctrl #(
    parameter logic [15:0] ADDR_SW   = 16'hFFF0,
    parameter logic [15:0] ADDR_STAT = 16'hFFF2,
    parameter logic [15:0] ADDR_DISP = 16'hFFF4,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] draddr,
    input  logic [15:0] dwdata,
    input  logic        dwrite,
    input  logic        dread,
    input  logic        io_sw0,
    input  logic        io_sw1,
    output logic [15:0] io_rdata,
    output logic        io_hit,
    output logic [6:0]  io_display
);

    // The last count before the stable value flips; the counter never goes past it.
    localparam logic [15:0] CNT_MAX = 16'(DB_CYCLES - 1);

    logic [1:0]       s1_q, s2_q;
    logic [1:0]       st_q, st_d;
    logic [1:0]       chg_q, chg_d;
    logic [1:0][15:0] cnt_q, cnt_d;
    logic [3:0]       dval_q, dval_d;
    logic             blank_q, blank_d;
    logic             hit_sw, hit_stat, hit_disp;
    logic             rd_stat, wr_disp;
    logic [6:0]       seg;
    logic             unused_wdata;

    // The upper write-data bits have no backing storage.
    assign unused_wdata = ^dwdata[15:5];

    assign hit_sw   = (draddr == ADDR_SW);
    assign hit_stat = (draddr == ADDR_STAT);
    assign hit_disp = (draddr == ADDR_DISP);
    assign io_hit   = hit_sw | hit_stat | hit_disp;
    assign rd_stat  = dread & hit_stat;
    assign wr_disp  = dwrite & hit_disp;

    // Debounce counters and sticky flags. A flag set on this edge overrides a clear-on-read on the same edge.
    always_comb begin
        st_d  = st_q;
        chg_d = rd_stat ? 2'b00 : chg_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == st_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                st_d[i]  = s2_q[i];
                cnt_d[i] = '0;
                chg_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Display register write. Writes to the switch and status addresses are ignored.
    always_comb begin
        dval_d  = dval_q;
        blank_d = blank_q;
        if (wr_disp) begin
            dval_d  = dwdata[3:0];
            blank_d = dwdata[4];
        end
    end

    // All state registers, including the two-flop synchronizers on the raw switches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            st_q    <= '0;
            chg_q   <= '0;
            cnt_q   <= '0;
            dval_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            s1_q    <= {io_sw1, io_sw0};
            s2_q    <= s1_q;
            st_q    <= st_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            dval_q  <= dval_d;
            blank_q <= blank_d;
        end
    end

    // Combinational read mux. Returning pre-edge state makes a read that coincides with a write see the old value.
    always_comb begin
        io_rdata = '0;
        if (dread) begin
            if (hit_sw)        io_rdata = {14'b0, st_q};
            else if (hit_stat) io_rdata = {14'b0, chg_q};
            else if (hit_disp) io_rdata = {11'b0, blank_q, dval_q};
        end
    end

    // Hex to active-high segments {g,f,e,d,c,b,a}.
    always_comb begin
        case (dval_q)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
    end

    assign io_display = blank_q ? 7'b0000000 : seg;

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

    localparam logic [15:0] A_SW   = 16'hFFF0;
    localparam logic [15:0] A_STAT = 16'hFFF2;
    localparam logic [15:0] A_DISP = 16'hFFF4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] draddr = '0;
    logic [15:0] dwdata = '0;
    logic        dwrite = 1'b0;
    logic        dread = 1'b0;
    logic        io_sw0 = 1'b0;
    logic        io_sw1 = 1'b0;
    logic [15:0] io_rdata;
    logic        io_hit;
    logic [6:0]  io_display;

    logic [15:0] sb[$];
    logic [15:0] got, exp;
    logic        h;
    int          n_cmp = 0;
    int          n_err = 0;

    io_port_ctrl #(.DB_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .draddr(draddr), .dwdata(dwdata),
        .dwrite(dwrite), .dread(dread), .io_sw0(io_sw0), .io_sw1(io_sw1),
        .io_rdata(io_rdata), .io_hit(io_hit), .io_display(io_display)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    // Reference 7-segment table {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Single-cycle read pulse, issued mid-cycle and dropped before the next rising edge.
    task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic hit);
        draddr = a; dread = 1'b1; #1;
        d = io_rdata; hit = io_hit;
        dread = 1'b0; #1;
    endtask

    task automatic test_reset;
        #2;
        sb.push_back(16'h003F); got = {9'b0, io_display}; exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_disp got=%h exp=%h", got, exp); end
        sb.push_back(16'h0000); rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_sw got=%h exp=%h", got, exp); end
        sb.push_back(16'h0000); rd(A_STAT, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_stat got=%h exp=%h", got, exp); end
        sb.push_back(16'h0000); rd(A_DISP, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_dispreg got=%h exp=%h", got, exp); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_debounce;
        @(negedge clock); io_sw0 = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        sb.push_back(16'h0000); sb.push_back(16'h0000);
        rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL deb_sw_e5 got=%h exp=%h", got, exp); end
        rd(A_STAT, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL deb_stat_e5 got=%h exp=%h", got, exp); end
        @(negedge clock);
        sb.push_back(16'h0001); sb.push_back(16'h0001);
        rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL deb_sw_e6 got=%h exp=%h", got, exp); end
        rd(A_STAT, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL deb_stat_e6 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_clear_on_read;
        // Read held across an edge clears the flag
        @(negedge clock); draddr = A_STAT; dread = 1'b1; #1;
        sb.push_back(16'h0001); got = io_rdata; exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL cor_first got=%h exp=%h", got, exp); end
        @(posedge clock); #1;
        sb.push_back(16'h0000); got = io_rdata; exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL cor_cleared got=%h exp=%h", got, exp); end
        dread = 1'b0;
        // Flag set on the same edge as a clearing read survives
        @(negedge clock); io_sw0 = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); draddr = A_STAT; dread = 1'b1; #1;
        sb.push_back(16'h0000); got = io_rdata; exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL cor_pre got=%h exp=%h", got, exp); end
        @(posedge clock); #1; dread = 1'b0;
        @(negedge clock);
        sb.push_back(16'h0001); rd(A_STAT, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL cor_setwins got=%h exp=%h", got, exp); end
        sb.push_back(16'h0000); rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL cor_sw got=%h exp=%h", got, exp); end
        @(negedge clock); draddr = A_STAT; dread = 1'b1;
        @(posedge clock); #1; dread = 1'b0;
        @(negedge clock);
        sb.push_back(16'h0000); rd(A_STAT, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL cor_final got=%h exp=%h", got, exp); end
    endtask

    task automatic test_glitch;
        @(negedge clock); io_sw1 = 1'b1;
        repeat (3) @(negedge clock);
        io_sw1 = 1'b0;
        repeat (8) @(negedge clock);
        sb.push_back(16'h0000); rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL glitch_sw got=%h exp=%h", got, exp); end
        sb.push_back(16'h0000); rd(A_STAT, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL glitch_stat got=%h exp=%h", got, exp); end
    endtask

    task automatic test_display;
        logic [15:0] wv [3];
        logic [15:0] rv [3];
        logic [6:0]  sv [3];
        for (int v = 0; v < 16; v++) begin
            @(negedge clock); draddr = A_DISP; dwdata = 16'(v); dwrite = 1'b1;
            sb.push_back({9'b0, hex7(4'(v))}); sb.push_back(16'(v));
            @(negedge clock); dwrite = 1'b0;
            got = {9'b0, io_display}; exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL disp_seg_%0d got=%h exp=%h", v, got, exp); end
            rd(A_DISP, got, h); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL disp_rd_%0d got=%h exp=%h", v, got, exp); end
        end
        // Upper bits ignored, blank bit, then a write to the read-only switch address
        wv[0] = 16'hFFE8; rv[0] = 16'h0008; sv[0] = 7'h7F;
        wv[1] = 16'h0013; rv[1] = 16'h0013; sv[1] = 7'h00;
        wv[2] = 16'h0005; rv[2] = 16'h0013; sv[2] = 7'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); draddr = (k == 2) ? A_SW : A_DISP; dwdata = wv[k]; dwrite = 1'b1;
            sb.push_back({9'b0, sv[k]}); sb.push_back(rv[k]); sb.push_back(16'h0000);
            @(negedge clock); dwrite = 1'b0;
            got = {9'b0, io_display}; exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL dispw_seg_%0d got=%h exp=%h", k, got, exp); end
            rd(A_DISP, got, h); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL dispw_rd_%0d got=%h exp=%h", k, got, exp); end
            rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL dispw_sw_%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_back_to_back;
        // Simultaneous read and write: old value now, new value after the edge
        @(negedge clock); draddr = A_DISP; dwdata = 16'h0002; dwrite = 1'b1; dread = 1'b1; #1;
        sb.push_back(16'h0013); got = io_rdata; exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rw_old got=%h exp=%h", got, exp); end
        sb.push_back(16'h0002); sb.push_back(16'h005B);
        @(negedge clock); dwrite = 1'b0; dread = 1'b0;
        rd(A_DISP, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rw_new got=%h exp=%h", got, exp); end
        got = {9'b0, io_display}; exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rw_seg got=%h exp=%h", got, exp); end
    endtask

    task automatic test_decode;
        logic [15:0] av [4];
        logic        dv [4];
        logic [15:0] ev [4];
        logic        hv [4];
        av[0] = 16'h0004; dv[0] = 1'b1; ev[0] = 16'h0000; hv[0] = 1'b0;
        av[1] = 16'hFFF4; dv[1] = 1'b1; ev[1] = 16'h0002; hv[1] = 1'b1;
        av[2] = 16'hFFF0; dv[2] = 1'b0; ev[2] = 16'h0000; hv[2] = 1'b1;
        av[3] = 16'hFFF3; dv[3] = 1'b1; ev[3] = 16'h0000; hv[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); draddr = av[k]; dread = dv[k];
            sb.push_back(ev[k]); sb.push_back({15'b0, hv[k]}); #1;
            got = io_rdata; exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL dec_rdata_%0d got=%h exp=%h", k, got, exp); end
            got = {15'b0, io_hit}; exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL dec_hit_%0d got=%h exp=%h", k, got, exp); end
            dread = 1'b0;
        end
    endtask

    task automatic test_reset_mid_debounce;
        @(negedge clock); io_sw0 = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock); reset = 1'b0; #1;
        sb.push_back(16'h003F); got = {9'b0, io_display}; exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rmid_disp got=%h exp=%h", got, exp); end
        sb.push_back(16'h0000); rd(A_DISP, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rmid_dispreg got=%h exp=%h", got, exp); end
        @(negedge clock); reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        sb.push_back(16'h0000); rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rmid_sw_e5 got=%h exp=%h", got, exp); end
        @(negedge clock);
        sb.push_back(16'h0001); sb.push_back(16'h0001);
        rd(A_SW, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rmid_sw_e6 got=%h exp=%h", got, exp); end
        rd(A_STAT, got, h); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rmid_stat_e6 got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_clear_on_read;
        test_glitch;
        test_display;
        test_back_to_back;
        test_decode;
        test_reset_mid_debounce;
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
